push_pop_sequencer: RTL and testbench



---
 rtl/push_pop_sequencer_pkg.sv | 24 ++
 rtl/push_pop_sequencer_enc.sv | 17 +
 rtl/push_pop_sequencer.sv | 149 ++++++++++++++
 tb/tb_push_pop_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/push_pop_sequencer_pkg.sv
// Shared definitions for the PUSH/POP register-list sequencer: widths,
// special register numbers and FSM state encoding.
package push_pop_sequencer_pkg;
  localparam int WORD       = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int NUM_REGS   = 16;

  localparam logic [ADDR_WIDTH-1:0] SP_REG_NUM = 4'd13;
  localparam logic [ADDR_WIDTH-1:0] PC_REG_NUM = 4'd15;

  typedef logic [2:0] seq_state_t;
  localparam seq_state_t S_IDLE       = 3'd0;
  localparam seq_state_t S_PUSH_PRIME = 3'd1;
  localparam seq_state_t S_PUSH_XFER  = 3'd2;
  localparam seq_state_t S_POP_XFER   = 3'd3;
  localparam seq_state_t S_SP_WB      = 3'd4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c = c + {4'd0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/push_pop_sequencer_enc.sv
// Lowest-set-bit encoder over a 16-bit register list: index of the lowest
// set bit, a valid flag, and the list with that bit cleared.
module lsb_prio_enc16 (
  input  logic [15:0] list_i,
  output logic [3:0]  idx_o,
  output logic        valid_o,
  output logic [15:0] rest_o
);
  assign valid_o = |list_i;
  assign rest_o  = list_i & (list_i - 16'd1);

  always_comb begin
    idx_o = '0;
    for (int i = 15; i >= 0; i--)
      if (list_i[i]) idx_o = 4'(i);
  end
endmodule

// File: rtl/push_pop_sequencer.sv
// Multi-cycle PUSH/POP register-list sequencer, one register per memory
// transfer. SEQ_SP_WRITEBACK_EN enables the SP register write in SP_WB.
module push_pop_sequencer
  import push_pop_sequencer_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  input  logic                  is_pop_i,
  input  logic [NUM_REGS-1:0]   reg_list_i,
  input  logic [WORD-1:0]       sp_i,
  input  logic [WORD-1:0]       reg_data_i,
  input  logic                  mem_ready_i,
  input  logic [WORD-1:0]       mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] read_addr_o,
  output logic                  reg_write_en_o,
  output logic [ADDR_WIDTH-1:0] write_addr_o,
  output logic [WORD-1:0]       reg_wdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [WORD-1:0]       mem_addr_o,
  output logic [WORD-1:0]       mem_wdata_o,
  output logic                  branch_o,
  output logic [WORD-1:0]       branch_target_o
);
  seq_state_t          state_q, state_d;
  logic [NUM_REGS-1:0] list_q, list_d;
  logic [WORD-1:0]     addr_q, addr_d;
  logic                done_q, done_d;
`ifdef SEQ_SP_WRITEBACK_EN
  logic [WORD-1:0]     new_sp_q, new_sp_d;
`endif

  logic [3:0]  cur_idx, nxt_idx;
  logic        cur_vld, nxt_vld;
  logic [15:0] list_rest, list_rest2;
  logic        unused_bits;

  // Second encoder looks one register ahead so the read address can advance
  // in the same cycle a store is accepted.
  lsb_prio_enc16 u_cur (.list_i(list_q),    .idx_o(cur_idx), .valid_o(cur_vld), .rest_o(list_rest));
  lsb_prio_enc16 u_nxt (.list_i(list_rest), .idx_o(nxt_idx), .valid_o(nxt_vld), .rest_o(list_rest2));
  assign unused_bits = ^{cur_vld, list_rest2};

  logic [WORD-1:0] span;
  assign span = WORD'(popcount16(reg_list_i)) << 2;

  always_comb begin
    state_d = state_q;
    list_d  = list_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
`ifdef SEQ_SP_WRITEBACK_EN
    new_sp_d = new_sp_q;
`endif
    case (state_q)
      S_IDLE: if (start_i) begin
        if (reg_list_i == '0) begin
          done_d = 1'b1;
        end else begin
          list_d  = reg_list_i;
          addr_d  = is_pop_i ? sp_i : sp_i - span;
          state_d = is_pop_i ? S_POP_XFER : S_PUSH_PRIME;
`ifdef SEQ_SP_WRITEBACK_EN
          new_sp_d = is_pop_i ? sp_i + span : sp_i - span;
`endif
        end
      end
      S_PUSH_PRIME: state_d = S_PUSH_XFER;
      S_PUSH_XFER, S_POP_XFER: if (mem_ready_i) begin
        list_d = list_rest;
        addr_d = addr_q + WORD'(4);
        if (!nxt_vld) state_d = S_SP_WB;
      end
      S_SP_WB: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      list_q  <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
`ifdef SEQ_SP_WRITEBACK_EN
      new_sp_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      list_q  <= list_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
`ifdef SEQ_SP_WRITEBACK_EN
      new_sp_q <= new_sp_d;
`endif
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = done_q | (state_q == S_SP_WB);

  always_comb begin
    read_addr_o     = '0;
    reg_write_en_o  = 1'b0;
    write_addr_o    = '0;
    reg_wdata_o     = '0;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_addr_o      = '0;
    mem_wdata_o     = '0;
    branch_o        = 1'b0;
    branch_target_o = '0;
    case (state_q)
      S_PUSH_PRIME: read_addr_o = cur_idx;
      S_PUSH_XFER: begin
        read_addr_o = mem_ready_i ? nxt_idx : cur_idx;
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = addr_q;
        mem_wdata_o = reg_data_i;
      end
      S_POP_XFER: begin
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        if (mem_ready_i) begin
          if (cur_idx == PC_REG_NUM) begin
            branch_o        = 1'b1;
            branch_target_o = mem_rdata_i;
          end else if (cur_idx != SP_REG_NUM) begin
            reg_write_en_o = 1'b1;
            write_addr_o   = cur_idx;
            reg_wdata_o    = mem_rdata_i;
          end
        end
      end
      S_SP_WB: begin
`ifdef SEQ_SP_WRITEBACK_EN
        reg_write_en_o = 1'b1;
        write_addr_o   = SP_REG_NUM;
        reg_wdata_o    = new_sp_q;
`endif
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_push_pop_sequencer.sv
// Scoreboard bench for push_pop_sequencer: reference model expands each
// register-list op into expected transfer events, a monitor checks them.
module tb_push_pop_sequencer;
  logic        clk, rst_n_i, start_i, is_pop_i, mem_ready_i;
  logic [15:0] reg_list_i;
  logic [31:0] sp_i, reg_data_i, mem_rdata_i;
  logic        busy_o, done_o, reg_write_en_o, mem_req_o, mem_we_o, branch_o;
  logic [3:0]  read_addr_o, write_addr_o;
  logic [31:0] reg_wdata_o, mem_addr_o, mem_wdata_o, branch_target_o;

  push_pop_sequencer dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .is_pop_i(is_pop_i),
    .reg_list_i(reg_list_i), .sp_i(sp_i), .reg_data_i(reg_data_i),
    .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o),
    .done_o(done_o), .read_addr_o(read_addr_o), .reg_write_en_o(reg_write_en_o),
    .write_addr_o(write_addr_o), .reg_wdata_o(reg_wdata_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .branch_o(branch_o), .branch_target_o(branch_target_o));

  typedef struct {
    logic mw, mr; logic [31:0] addr, wdata;
    logic rw; logic [3:0] waddr; logic [31:0] rdata;
    logic br; logic [31:0] tgt; logic dn; int lat;
  } ev_t;

  ev_t exp_q[$];
  int total = 0, bad = 0, cyc = 0, st_cyc = 0;
  int ready_mode = 0, stallcnt = 0;
  logic [3:0]  rd_pend = '0;
  logic [31:0] regs[16], mregs[16], snap[16];
  logic [31:0] mem[logic [31:0]], mmem[logic [31:0]];
  bit prev_stall = 0;
  logic [31:0] ps_addr, ps_wdata; logic [3:0] ps_ra;

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial begin #3000000; $display("FAIL watchdog expired"); $fatal(1, "watchdog"); end

  function automatic logic [31:0] dflt(input logic [31:0] a); return a ^ 32'hC0DE_0000; endfunction
  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction
  function automatic logic [31:0] rd_mmem(input logic [31:0] a);
    return mmem.exists(a) ? mmem[a] : dflt(a);
  endfunction

  // Environment: registered-read register file and memory responder.
  initial begin
    mem_ready_i = 0; mem_rdata_i = 0; reg_data_i = 0;
    forever begin
      @(negedge clk);
      reg_data_i  = regs[rd_pend];
      mem_rdata_i = (mem_req_o && !mem_we_o) ? rd_mem(mem_addr_o) : 32'h0;
      case (ready_mode)
        0: mem_ready_i = 1'b1;
        1: mem_ready_i = 1'($urandom_range(0, 1));
        default: begin
          mem_ready_i = (stallcnt >= 3);
          if (mem_req_o) stallcnt++;
        end
      endcase
    end
  end

  // Monitor: forms one observed event per cycle and checks it against the queue.
  initial begin
    ev_t o, e;
    forever begin
      @(negedge clk); #2;
      if (!rst_n_i) begin
        rd_pend = '0; prev_stall = 0;
      end else begin
        cyc++;
        if (start_i && !busy_o) st_cyc = cyc;
        o = '{default: 0};
        o.mw = mem_req_o && mem_we_o && mem_ready_i;
        o.mr = mem_req_o && !mem_we_o && mem_ready_i;
        if (o.mw || o.mr) o.addr = mem_addr_o;
        if (o.mw) o.wdata = mem_wdata_o;
        o.rw = reg_write_en_o;
        if (o.rw) begin o.waddr = write_addr_o; o.rdata = reg_wdata_o; end
        o.br = branch_o;
        if (o.br) o.tgt = branch_target_o;
        o.dn = done_o;
        if (mem_req_o && !mem_ready_i) begin
          if (prev_stall) begin
            total++;
            if (mem_addr_o !== ps_addr || mem_wdata_o !== ps_wdata || read_addr_o !== ps_ra) begin
              bad++;
              $display("FAIL stall_hold: got addr=%h wd=%h ra=%0d exp addr=%h wd=%h ra=%0d",
                       mem_addr_o, mem_wdata_o, read_addr_o, ps_addr, ps_wdata, ps_ra);
            end
          end
          prev_stall = 1; ps_addr = mem_addr_o; ps_wdata = mem_wdata_o; ps_ra = read_addr_o;
        end else prev_stall = 0;
        if (o.mw) mem[o.addr] = o.wdata;
        if (o.rw) regs[o.waddr] = o.rdata;
        rd_pend = read_addr_o;
        if (o.mw || o.mr || o.rw || o.br || o.dn) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got mw=%0d mr=%0d addr=%h rw=%0d wa=%0d br=%0d dn=%0d exp none",
                     o.mw, o.mr, o.addr, o.rw, o.waddr, o.br, o.dn);
          end else begin
            e = exp_q.pop_front();
            if (o.mw !== e.mw || o.mr !== e.mr || o.addr !== e.addr || o.wdata !== e.wdata ||
                o.rw !== e.rw || o.waddr !== e.waddr || o.rdata !== e.rdata ||
                o.br !== e.br || o.tgt !== e.tgt || o.dn !== e.dn) begin
              bad++;
              $display("FAIL event: got mw=%0d mr=%0d a=%h wd=%h rw=%0d wa=%0d rd=%h br=%0d tg=%h dn=%0d exp mw=%0d mr=%0d a=%h wd=%h rw=%0d wa=%0d rd=%h br=%0d tg=%h dn=%0d",
                       o.mw, o.mr, o.addr, o.wdata, o.rw, o.waddr, o.rdata, o.br, o.tgt, o.dn,
                       e.mw, e.mr, e.addr, e.wdata, e.rw, e.waddr, e.rdata, e.br, e.tgt, e.dn);
            end
            if (o.dn && e.dn && e.lat >= 0) begin
              total++;
              if (cyc - st_cyc != e.lat) begin
                bad++;
                $display("FAIL done_latency: got %0d exp %0d", cyc - st_cyc, e.lat);
              end
            end
          end
        end
      end
    end
  end

  // Reference model: expand the op into per-register transfers plus completion.
  task automatic do_op(input bit pop, input logic [15:0] lst, input logic [31:0] sp, input int mode);
    ev_t e; int n; logic [31:0] base, nsp, a, d;
    ready_mode = mode; stallcnt = 0;
    n = $countones(lst);
    if (n == 0) begin
      e = '{default: 0}; e.dn = 1; e.lat = 1; exp_q.push_back(e);
    end else begin
      base = pop ? sp : sp - 32'(4 * n);
      nsp  = pop ? sp + 32'(4 * n) : base;
      a = base;
      for (int r = 0; r < 16; r++) if (lst[r]) begin
        e = '{default: 0};
        if (!pop) begin
          e.mw = 1; e.addr = a; e.wdata = mregs[r]; mmem[a] = mregs[r];
        end else begin
          e.mr = 1; e.addr = a; d = rd_mmem(a);
          if (r == 15) begin e.br = 1; e.tgt = d; end
          else if (r != 13) begin e.rw = 1; e.waddr = 4'(r); e.rdata = d; mregs[r] = d; end
        end
        exp_q.push_back(e);
        a = a + 32'd4;
      end
      e = '{default: 0}; e.dn = 1;
`ifdef SEQ_SP_WRITEBACK_EN
      e.rw = 1; e.waddr = 4'd13; e.rdata = nsp; mregs[13] = nsp;
`endif
      e.lat = (mode == 0) ? (pop ? n + 1 : n + 2) : -1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start_i = 1; is_pop_i = pop; reg_list_i = lst; sp_i = sp;
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge clk); k++; end while ((exp_q.size() != 0 || busy_o) && k < 2000);
    total++;
    if (k >= 2000) begin
      bad++; $display("FAIL idle_timeout: got pending=%0d exp 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic check_bit(input string nm, input logic got, input logic expv);
    total++;
    if (got !== expv) begin bad++; $display("FAIL %s: got %b exp %b", nm, got, expv); end
  endtask

  task automatic check_zero(input string nm);
    total++;
    if ({busy_o, done_o, read_addr_o, reg_write_en_o, write_addr_o, reg_wdata_o, mem_req_o,
         mem_we_o, mem_addr_o, mem_wdata_o, branch_o, branch_target_o} !== '0) begin
      bad++;
      $display("FAIL %s: got busy=%b done=%b ra=%0d we=%b wa=%0d req=%b mwe=%b ma=%h br=%b exp all 0",
               nm, busy_o, done_o, read_addr_o, reg_write_en_o, write_addr_o, mem_req_o,
               mem_we_o, mem_addr_o, branch_o);
    end
  endtask

  initial begin
    bit pop; logic [15:0] lst; logic [31:0] sp; int mode, diffs;
    rst_n_i = 0; start_i = 0; is_pop_i = 0; reg_list_i = '0; sp_i = '0;
    for (int i = 0; i < 16; i++) begin regs[i] = $urandom; mregs[i] = regs[i]; end
    #2; check_zero("reset_outputs");
    repeat (3) @(negedge clk);
    rst_n_i = 1;
    @(negedge clk); check_zero("post_reset_idle");

    do_op(0, 16'h4011, 32'h1000, 0);
    check_bit("busy_after_start", busy_o, 1'b1);
    wait_idle();

    mem[32'hFF4] = 32'hA; mem[32'hFF8] = 32'hB; mem[32'hFFC] = 32'h200;
    mmem[32'hFF4] = 32'hA; mmem[32'hFF8] = 32'hB; mmem[32'hFFC] = 32'h200;
    do_op(1, 16'h8006, 32'hFF4, 0);
    wait_idle();

    do_op(0, 16'h0008, 32'h2000, 2);
    wait_idle();

    do_op(0, 16'h0000, 32'h3000, 0);
    check_bit("busy_empty_list", busy_o, 1'b0);
    wait_idle();

    do_op(0, 16'h0060, 32'h3000, 0);
    start_i = 1; is_pop_i = 1; reg_list_i = 16'hFFFF;
    @(negedge clk); start_i = 0;
    wait_idle();

    do_op(0, 16'h0003, 32'h4, 0);
    wait_idle();

    repeat (40) begin
      pop  = 1'($urandom_range(0, 1));
      lst  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      sp   = $urandom & 32'hFFFF_FFFC;
      mode = $urandom_range(0, 1);
      do_op(pop, lst, sp, mode);
      wait_idle();
    end

    do_op(1, 16'h00F0, 32'h500, 0);
    @(negedge clk); #3;
    rst_n_i = 0;
    #1; check_zero("reset_mid_pop");
    exp_q.delete();
    for (int i = 0; i < 16; i++) snap[i] = regs[i];
    repeat (3) @(negedge clk);
    rst_n_i = 1;
    repeat (4) @(negedge clk);
    diffs = 0;
    for (int i = 0; i < 16; i++) if (regs[i] !== snap[i]) diffs++;
    total++;
    if (diffs != 0) begin bad++; $display("FAIL no_writes_after_reset: got %0d changed regs exp 0", diffs); end
    check_bit("idle_after_reset", busy_o, 1'b0);

    total++;
    if (exp_q.size() != 0) begin bad++; $display("FAIL leftover_expected: got %0d exp 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
